// File: rtl/toggle_chk_pkg.sv
// Shared types and default constants for the toggle checker.
package toggle_chk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StLocked
    } state_e;

    localparam int unsigned DefLockCnt = 4;
    localparam int unsigned DefLossCnt = 3;
    localparam int unsigned DefCntW    = 16;

endpackage

// File: rtl/toggle_chk_satcnt.sv
// Saturating error counter with synchronous clear; clear wins over increment.
module toggle_chk_satcnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/toggle_checker.sv
// Checks that every bit of a toggles each cycle; locks, then gathers error statistics.
// Define TOGGLE_CHK_FIRST_FAIL_EN to capture the lowest failing bit of the first error.
module toggle_checker
    import toggle_chk_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned LOCK_CNT = DefLockCnt,
    parameter int unsigned LOSS_CNT = DefLossCnt,
    parameter int unsigned CNT_W    = DefCntW
) (
    input  logic                     c,
    input  logic                     r,
    input  logic [WIDTH-1:0]         a,
    input  logic                     en,
    input  logic                     clr,
    output logic                     locked,
    output logic                     err,
    output logic [CNT_W-1:0]         err_count,
    output logic [WIDTH-1:0]         err_mask,
    output logic [$clog2(WIDTH)-1:0] first_idx,
    output logic                     first_vld
);

    localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
    localparam int unsigned BadW  = $clog2(LOSS_CNT + 1);
    localparam int unsigned IdxW  = $clog2(WIDTH);

    state_e           state_d, state_q;
    logic [WIDTH-1:0] prev_q;
    logic [GoodW-1:0] good_cnt_d, good_cnt_q;
    logic [BadW-1:0]  bad_cnt_d, bad_cnt_q;
    logic             err_d, err_q;
    logic [WIDTH-1:0] err_mask_d, err_mask_q;
    logic [WIDTH-1:0] mis;
    logic             good;
    logic             hit;

    always_comb begin
        mis        = a ^ ~prev_q;
        good       = ~|mis;
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (!en) begin
            state_d    = StIdle;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d    = StSync;
                    good_cnt_d = '0;
                    bad_cnt_d  = '0;
                end
                StSync: begin
                    if (!good) begin
                        good_cnt_d = '0;
                    end else if (good_cnt_q + GoodW'(1) == GoodW'(LOCK_CNT)) begin
                        state_d    = StLocked;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + GoodW'(1);
                    end
                end
                StLocked: begin
                    if (good) begin
                        bad_cnt_d = '0;
                    end else if (bad_cnt_q + BadW'(1) == BadW'(LOSS_CNT)) begin
                        state_d    = StSync;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + BadW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Statistics only move on a bad cycle that is both enabled and locked.
    assign hit = en && (state_q == StLocked) && !good;

    always_comb begin
        err_d      = clr ? 1'b0 : (err_q | hit);
        err_mask_d = clr ? '0 : (err_mask_q | (hit ? mis : '0));
    end

    always_ff @(posedge c) begin
        if (r) begin
            state_q    <= StIdle;
            prev_q     <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            err_q      <= 1'b0;
            err_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= a;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            err_q      <= err_d;
            err_mask_q <= err_mask_d;
        end
    end

    toggle_chk_satcnt #(
        .Width(CNT_W)
    ) u_satcnt (
        .clk_i(c),
        .rst_i(r),
        .clr_i(clr),
        .inc_i(hit),
        .cnt_o(err_count)
    );

`ifdef TOGGLE_CHK_FIRST_FAIL_EN
    logic [IdxW-1:0] low_idx;
    logic [IdxW-1:0] first_idx_d, first_idx_q;
    logic            first_vld_d, first_vld_q;

    always_comb begin
        low_idx = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (mis[i]) low_idx = IdxW'(i);
        end
        first_idx_d = first_idx_q;
        first_vld_d = first_vld_q;
        if (clr) begin
            first_idx_d = '0;
            first_vld_d = 1'b0;
        end else if (hit && !first_vld_q) begin
            first_idx_d = low_idx;
            first_vld_d = 1'b1;
        end
    end

    always_ff @(posedge c) begin
        if (r) begin
            first_idx_q <= '0;
            first_vld_q <= 1'b0;
        end else begin
            first_idx_q <= first_idx_d;
            first_vld_q <= first_vld_d;
        end
    end

    assign first_idx = first_idx_q;
    assign first_vld = first_vld_q;
`else
    assign first_idx = '0;
    assign first_vld = 1'b0;
`endif

    assign locked   = (state_q == StLocked);
    assign err      = err_q;
    assign err_mask = err_mask_q;

endmodule
